// File: rtl/packet_serializer.sv
`default_nettype none
// packet_serializer: captures the scheduler-selected packet once the selector tree has settled,
// acknowledges it with a one-cycle consumed pulse, and replays it LSB-first as valid/ready beats.
module packet_serializer #(
    parameter int DATA_SIZE      = 678,
    parameter int BEAT_WIDTH     = 128,
    parameter int SELECT_LATENCY = 1,
    parameter int REGISTER_SIZE  = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [DATA_SIZE-1:0]     packet_i,
    input  logic                     activate_i,
    output logic                     consumed_o,
    output logic [BEAT_WIDTH-1:0]    out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic [REGISTER_SIZE-1:0] packets_sent_o
);
    localparam int NUM_BEATS   = (DATA_SIZE + BEAT_WIDTH - 1) / BEAT_WIDTH;
    localparam int TOTAL_W     = NUM_BEATS * BEAT_WIDTH;
    localparam int BEAT_IDX_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int WAIT_INIT_I = (SELECT_LATENCY > 0) ? SELECT_LATENCY - 1 : 0;
    localparam logic [3:0] WAIT_INIT = WAIT_INIT_I[3:0];
    localparam logic [BEAT_IDX_W-1:0] PENULT_BEAT =
        BEAT_IDX_W'((NUM_BEATS > 1) ? NUM_BEATS - 2 : 0);
    localparam logic ONE_BEAT = (NUM_BEATS == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t                   state_q;
    logic [TOTAL_W-1:0]       shift_q;
    logic [TOTAL_W-1:0]       packet_ext_d;
    logic [BEAT_IDX_W-1:0]    beat_q;
    logic [3:0]               wait_q;
    logic                     consumed_q;
    logic                     valid_q;
    logic                     last_q;
    logic [REGISTER_SIZE-1:0] sent_q;
    logic [REGISTER_SIZE-1:0] sent_d;
    logic                     capture_d;
    logic                     handshake_d;

    // Zero-extend so the pad bits of the final beat always read as 0.
    always_comb begin
        packet_ext_d                = '0;
        packet_ext_d[DATA_SIZE-1:0] = packet_i;
    end

    assign capture_d   = ((state_q == S_IDLE) && activate_i && (SELECT_LATENCY == 0)) ||
                         ((state_q == S_WAIT) && (wait_q == 4'd0));
    assign handshake_d = valid_q && out_ready_i;
    assign sent_d      = sent_q + 1'b1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            beat_q     <= '0;
            wait_q     <= 4'd0;
            consumed_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            sent_q     <= '0;
        end else begin
            consumed_q <= capture_d;
            case (state_q)
                S_IDLE: begin
                    if (activate_i && (SELECT_LATENCY != 0)) begin
                        wait_q  <= WAIT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_SEND: begin
                    if (handshake_d) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            shift_q <= '0;
                            sent_q  <= sent_d;
                            state_q <= S_IDLE;
                        end else begin
                            // The current beat always sits in the low slice of the shifter.
                            shift_q <= shift_q >> BEAT_WIDTH;
                            beat_q  <= beat_q + 1'b1;
                            last_q  <= (beat_q == PENULT_BEAT);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (capture_d) begin
                shift_q <= packet_ext_d;
                beat_q  <= '0;
                valid_q <= 1'b1;
                last_q  <= ONE_BEAT;
                state_q <= S_SEND;
            end
        end
    end

    assign consumed_o     = consumed_q;
    assign out_data_o     = shift_q[BEAT_WIDTH-1:0];
    assign out_valid_o    = valid_q;
    assign out_last_o     = last_q;
    assign busy_o         = (state_q != S_IDLE);
    assign packets_sent_o = sent_q;

endmodule
`default_nettype wire
